// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends the low L bits of a captured pattern MSB-first,
// one bit per clock, for repeat_cnt+1 frames with an optional idle gap between them.
module seq_pattern_tx #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [REP_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             busy,
  output logic             done,
  output logic             d_out,
  output logic             d_valid,
  output logic             d_last
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [PAT_W-1:0] pat_q, pat_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [LEN_W-1:0] idx_q, idx_n;
  logic [REP_W-1:0] frm_q, frm_n;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic [GAP_W-1:0] gcnt_q, gcnt_n;
  logic             busy_n, done_n, d_out_n, d_valid_n, d_last_n;
  logic [LEN_W-1:0] eff_len;

  // Zero or out-of-range lengths fall back to the full pattern width.
  assign eff_len = (pat_len == '0 || pat_len > PAT_W_L) ? PAT_W_L : pat_len;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      d_out   <= 1'b0;
      d_valid <= 1'b0;
      d_last  <= 1'b0;
    end else begin
      state   <= state_n;
      pat_q   <= pat_n;
      len_q   <= len_n;
      idx_q   <= idx_n;
      frm_q   <= frm_n;
      gap_q   <= gap_n;
      gcnt_q  <= gcnt_n;
      busy    <= busy_n;
      done    <= done_n;
      d_out   <= d_out_n;
      d_valid <= d_valid_n;
      d_last  <= d_last_n;
    end
  end

  // NOTE: every signal gets a default before the case statement; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_n   = state;
    pat_n     = pat_q;
    len_n     = len_q;
    idx_n     = idx_q;
    frm_n     = frm_q;
    gap_n     = gap_q;
    gcnt_n    = gcnt_q;
    busy_n    = busy;
    done_n    = 1'b0;
    d_out_n   = 1'b0;
    d_valid_n = 1'b0;
    d_last_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          pat_n     = pattern;
          len_n     = eff_len;
          frm_n     = repeat_cnt;
          gap_n     = gap_len;
          gcnt_n    = '0;
          idx_n     = eff_len - ONE_L;
          state_n   = SHIFT;
          busy_n    = 1'b1;
          d_valid_n = 1'b1;
          d_out_n   = pattern[IDX_W'(eff_len - ONE_L)];
          d_last_n  = (eff_len == ONE_L);
        end
      end

      SHIFT: begin
        if (idx_q != '0) begin
          idx_n     = idx_q - ONE_L;
          d_valid_n = 1'b1;
          d_out_n   = pat_q[IDX_W'(idx_q - ONE_L)];
          d_last_n  = (idx_q == ONE_L);
        end else if (frm_q != '0) begin
          frm_n = frm_q - REP_W'(1);
          if (gap_q != '0) begin
            // The entry edge is the first idle cycle, so count G-1 more.
            state_n = GAP;
            gcnt_n  = gap_q - GAP_W'(1);
          end else begin
            idx_n     = len_q - ONE_L;
            d_valid_n = 1'b1;
            d_out_n   = pat_q[IDX_W'(len_q - ONE_L)];
            d_last_n  = (len_q == ONE_L);
          end
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end

      GAP: begin
        if (gcnt_q != '0) begin
          gcnt_n = gcnt_q - GAP_W'(1);
        end else begin
          state_n   = SHIFT;
          idx_n     = len_q - ONE_L;
          d_valid_n = 1'b1;
          d_out_n   = pat_q[IDX_W'(len_q - ONE_L)];
          d_last_n  = (len_q == ONE_L);
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase

    // Abort overrides whatever the active state decided; it is a no-op in IDLE.
    if (abort && state != IDLE) begin
      state_n   = IDLE;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      d_out_n   = 1'b0;
      d_valid_n = 1'b0;
      d_last_n  = 1'b0;
      idx_n     = '0;
      frm_n     = '0;
      gcnt_n    = '0;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: each scenario is a start edge followed by a
// per-cycle string of expected {busy, done, d_valid, d_last, d_out} codes.
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] pat_len;
  logic [3:0] repeat_cnt;
  logic [3:0] gap_len;
  logic       busy, done, d_out, d_valid, d_last;

  int tests_run = 0;
  int tests_failed = 0;

  seq_pattern_tx #(
    .PAT_W(8), .LEN_W(4), .REP_W(4), .GAP_W(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .pat_len    (pat_len),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
    .busy       (busy),
    .done       (done),
    .d_out      (d_out),
    .d_valid    (d_valid),
    .d_last     (d_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, got[4:0], exp[4:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Codes: '0'/'1' data bit, 'z'/'o' last bit 0/1, '_' gap, 'D' done, '-' idle.
  function automatic logic [4:0] code(input byte c);
    case (c)
      "0":     return 5'b10100;
      "1":     return 5'b10101;
      "z":     return 5'b10110;
      "o":     return 5'b10111;
      "_":     return 5'b10000;
      "D":     return 5'b01000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] obs();
    return {busy, done, d_valid, d_last, d_out};
  endfunction

  // Edge numbers are relative to the start edge k; 0 disables the option.
  task automatic run_seq(input string tag, input logic [7:0] pat, input logic [3:0] len,
                         input logic [3:0] rep, input logic [3:0] gap, input string exp,
                         input int start_edge, input int abort_edge,
                         input int scramble_edge, input int hold_until);
    pattern    = pat;
    pat_len    = len;
    repeat_cnt = rep;
    gap_len    = gap;
    abort      = 1'b0;
    start      = 1'b1;
    tick();
    for (int i = 0; i < exp.len(); i++) begin
      check($sformatf("%s[%0d]", tag, i), 32'(obs()), 32'(code(exp[i])));
      start = ((i + 1) == start_edge) || ((i + 1) <= hold_until);
      abort = ((i + 1) == abort_edge);
      if ((i + 1) == scramble_edge) begin
        pattern    = ~pattern;
        pat_len    = pat_len + 4'd5;
        repeat_cnt = repeat_cnt + 4'd3;
        gap_len    = gap_len + 4'd2;
      end
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    pattern = 8'hFF;
    pat_len = 4'd4;
    repeat_cnt = 4'd0;
    gap_len = 4'd0;

    tick();
    check("reset_1", 32'(obs()), 32'd0);
    tick();
    check("reset_2", 32'(obs()), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    check("post_reset_idle", 32'(obs()), 32'd0);

    run_seq("basic_1011", 8'h0B, 4'd4, 4'd0, 4'd0, "101oD-", 0, 0, 0, 0);
    run_seq("clamp0_gap2", 8'hA5, 4'd0, 4'd1, 4'd2,
            "1010010o__1010010oD-", 0, 0, 0, 0);
    run_seq("len3_rep2_ign", 8'h06, 4'd3, 4'd2, 4'd0, "11z11z11zD-", 4, 0, 0, 0);
    run_seq("abort_restart", 8'hA5, 4'd0, 4'd1, 4'd2,
            "10100--1010010o__1010010oD-", 7, 5, 0, 0);
    run_seq("stable_inputs", 8'h0B, 4'd4, 4'd1, 4'd1, "101o_101oD-", 0, 0, 2, 0);
    run_seq("clamp12", 8'hC3, 4'd12, 4'd0, 4'd0, "1100001oD-", 0, 0, 0, 0);
    run_seq("len1_one", 8'h01, 4'd1, 4'd0, 4'd0, "oD-", 0, 0, 0, 0);
    run_seq("len1_zero_b2b", 8'hFE, 4'd1, 4'd1, 4'd0, "zzD-", 0, 0, 0, 0);
    run_seq("hold_retrigger", 8'h02, 4'd2, 4'd0, 4'd0, "1zD1zD-", 0, 0, 0, 3);
    run_seq("max_frames", 8'h01, 4'd1, 4'd15, 4'd0,
            "ooooooooooooooooD-", 0, 0, 0, 0);

    // Abort in IDLE alone, and together with start, must leave the line idle.
    pattern = 8'hFF;
    pat_len = 4'd4;
    abort = 1'b1;
    tick();
    check("abort_idle", 32'(obs()), 32'd0);
    start = 1'b1;
    tick();
    check("abort_start_same_edge", 32'(obs()), 32'd0);
    start = 1'b0;
    abort = 1'b0;
    tick();
    check("abort_start_after", 32'(obs()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
